// File: rtl/spi_dac_pkg.sv
// Shared definitions for the SPI DAC slave receiver.
//   DAC_FRAME_BITS : default frame length (sck falling edges per valid frame)
//   state_e        : receiver FSM states
//   CFG_*          : bit positions inside dac_cfg (frame bits [15:12])
package spi_dac_pkg;

  localparam int unsigned DAC_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    END       = 2'd3
  } state_e;

  localparam int unsigned CFG_AB   = 3;
  localparam int unsigned CFG_BUF  = 2;
  localparam int unsigned CFG_GA   = 1;
  localparam int unsigned CFG_SHDN = 0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (STAGES flops deep)
// Every stage resets to RST_VAL so the output starts at the line's idle level.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_dac_slave_rx.sv
// SPI slave receiver for a 12-bit DAC command word (mode 0, MSB first).
//   clk, rst         : system clock, synchronous active-high reset
//   cs_n, sck, mosi  : asynchronous SPI inputs from the master
//   dac_data [11:0]  : frame bits [11:0] of the last valid frame
//   dac_cfg  [3:0]   : frame bits [15:12] of the last valid frame (AB, BUF, GA, SHDN)
//   frame_valid      : one-clk pulse when a frame of exactly FRAME_BITS bits is accepted
//   frame_err        : one-clk pulse when a malformed frame is discarded
//   busy             : high while shifting a frame
module spi_dac_slave_rx
  import spi_dac_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DAC_FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        mosi,
  output logic [11:0] dac_data,
  output logic [3:0]  dac_cfg,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [4:0] COUNT_MAX = 5'd17;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  // Cycles cs_n must read high before leaving WAIT_IDLE. Must exceed the
  // synchronizer depth so the reset-forced idle level flushing out of the
  // chain cannot fake a cs_n falling edge mid-frame.
  localparam logic [4:0] SETTLE    = 5'(SYNC_STAGES + 1);

  logic cs_s, sck_s, mosi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  state_e      state_q, state_d;
  logic        cs_prev_q, cs_prev_d;
  logic        sck_prev_q, sck_prev_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic        pend_q, pend_d;
  logic [11:0] dac_data_q, dac_data_d;
  logic [3:0]  dac_cfg_q, dac_cfg_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  logic cs_rise, cs_fall, sck_fall;

  assign cs_rise  =  cs_s  & ~cs_prev_q;
  assign cs_fall  = ~cs_s  &  cs_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;

  always_comb begin
    state_d       = state_q;
    cs_prev_d     = cs_s;
    sck_prev_d    = sck_s;
    shift_d       = shift_q;
    count_d       = count_q;
    pend_d        = 1'b0;
    dac_data_d    = dac_data_q;
    dac_cfg_d     = dac_cfg_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        // The bit counter doubles as the cs_n-high settle timer here.
        if (cs_s) begin
          if (count_q == SETTLE) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 5'd1;
          end
        end else begin
          count_d = '0;
        end
      end
      IDLE: begin
        if (cs_fall || pend_q) begin
          state_d = SHIFT;
          shift_d = '0;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (sck_fall) begin
          shift_d = {shift_q[14:0], mosi_s};
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 5'd1;
          end
        end
        // Uses shift_d/count_d so a bit arriving with the cs_n rise counts.
        if (cs_rise) begin
          state_d = END;
          if (count_d == FRAME_CNT) begin
            dac_cfg_d     = shift_d[15:12];
            dac_data_d    = shift_d[11:0];
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d   = 1'b1;
          end
        end
      end
      END: begin
        state_d = IDLE;
        // A new frame starting during END is remembered for IDLE.
        pend_d  = cs_fall;
      end
      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_IDLE;
      cs_prev_q     <= 1'b1;
      sck_prev_q    <= 1'b0;
      shift_q       <= '0;
      count_q       <= '0;
      pend_q        <= 1'b0;
      dac_data_q    <= '0;
      dac_cfg_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_prev_q     <= cs_prev_d;
      sck_prev_q    <= sck_prev_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      dac_data_q    <= dac_data_d;
      dac_cfg_q     <= dac_cfg_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign dac_data    = dac_data_q;
  assign dac_cfg     = dac_cfg_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: doc/spi_dac_slave_rx.md
SPI_DAC_SLAVE_RX -- requirements
Module: spi_dac_slave_rx

Interface
REQ-001 Parameter FRAME_BITS, default 16, SHALL set the number of sck falling edges per valid frame.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on cs_n, sck and mosi.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cs_n  input  1  SHALL be the asynchronous SPI chip select from the master; low means a frame is active.
REQ-006 sck  input  1  SHALL be the asynchronous SPI clock; idle level is low.
REQ-007 mosi  input  1  SHALL be the asynchronous serial data, MSB first.
REQ-008 dac_data  output  12  SHALL hold frame bits [11:0] of the last valid frame.
REQ-009 dac_cfg  output  4  SHALL hold frame bits [15:12] of the last valid frame (A/B, BUF, GA, SHDN).
REQ-010 frame_valid  output  1  SHALL pulse high for one clk when a valid frame is accepted.
REQ-011 frame_err  output  1  SHALL pulse high for one clk when a malformed frame is discarded.
REQ-012 busy  output  1  SHALL be high while the block is in state SHIFT.

Function
REQ-013 cs_n, sck and mosi SHALL each pass through SYNC_STAGES flops before use; edge detection SHALL compare the last two synchronized samples.
REQ-014 mosi SHALL be sampled on each synchronized sck falling edge only, because the master changes mosi on the rising edge.
REQ-015 The shift register SHALL be 16 bits, shifting left with the new bit entering at the LSB.
REQ-016 The bit counter SHALL be 5 bits and saturate at 17.
REQ-017 The states SHALL be WAIT_IDLE, IDLE, SHIFT and END.
- WAIT_IDLE -> IDLE when synchronized cs_n is high.
- IDLE -> SHIFT on a synchronized cs_n falling edge; the shift register and counter clear.
- SHIFT -> END on a synchronized cs_n rising edge.
- END -> IDLE after one cycle.
REQ-018 In END with count == FRAME_BITS, the block SHALL load dac_cfg and dac_data from the shift register and pulse frame_valid.
REQ-019 In END with count != FRAME_BITS, the block SHALL pulse frame_err and leave dac_cfg and dac_data unchanged.
REQ-020 Latency SHALL be 1 clk from detection of the synchronized cs_n rising edge to the frame_valid or frame_err pulse.
REQ-021 If an sck falling edge and a cs_n rising edge are detected in the same cycle, the block SHALL shift the bit first, then count it toward the frame.
REQ-022 sck edges seen outside SHIFT SHALL be ignored.
REQ-023 A cs_n falling edge in END SHALL be honoured on the next IDLE cycle; with master sck at clk/8, no edge is lost.
REQ-024 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 On rst, the state SHALL go to WAIT_IDLE, so a frame already in progress is never captured.
REQ-026 On rst, dac_data, dac_cfg, frame_valid, frame_err, busy, the counter and the shift register SHALL all be 0.
REQ-027 On rst, all synchronizer flops SHALL be set to the idle levels: cs_n 1, sck 0, mosi 0.

Structure
REQ-028 FRAME_BITS, the state encoding and the cfg bit positions (AB=3, BUF=2, GA=1, SHDN=0) SHALL live in the shared package spi_dac_pkg.
REQ-029 The synchronizer SHALL be a sub-module, sync_ff, instanced once per input.
REQ-030 The implementation SHALL be 120-250 lines and contain no latches and no clock gating.

Verification
REQ-031 Send frame 0x5123 at sck = clk/8 -> dac_cfg=0x5, dac_data=0x123, and one frame_valid pulse.
REQ-032 Send a 12-bit frame, then release cs_n -> one frame_err pulse; dac_data keeps its previous value.
REQ-033 Send 17 sck edges with data 0xFFFF plus 1 -> frame_err; the outputs are unchanged.
REQ-034 Send back-to-back frames 0x5ABC and 0x5001 with 2 clk of cs_n high between them -> two frame_valid pulses, and final dac_data=0x001.
REQ-035 Assert rst after bit 8 of a frame, deassert it while cs_n is still low, then finish the frame -> no pulses; the next full frame 0x5FFF is accepted.
REQ-036 Drive the master module into this block as a loopback with pic_data=0x3FF -> dac_data=0x3FF and dac_cfg=0x5.
